// File: rtl/l2_line_responder_if.sv
// l2_line_responder_if
//   Handshake bundle between the L1 cache (master) and the L2 line
//   responder (slave).
//   Request channel  : req_valid/req_ready, req_type, req_addr, req_wdata
//   Response channel : resp_valid/resp_ready, resp_type, resp_data
//   Evict in (L2 ctl): evict_in_valid/evict_in_ready, evict_in_addr
//   Evict out (to L1): l1_evict_valid/l1_evict_ready, l1_evict_addr
interface l2_line_responder_if #(
    parameter int LINE_BITS = 512
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_type;
    logic [31:0]          req_addr;
    logic [LINE_BITS-1:0] req_wdata;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [1:0]           resp_type;
    logic [LINE_BITS-1:0] resp_data;

    logic                 evict_in_valid;
    logic                 evict_in_ready;
    logic [31:0]          evict_in_addr;

    logic                 l1_evict_valid;
    logic                 l1_evict_ready;
    logic [31:0]          l1_evict_addr;

    modport master (
        output req_valid, req_type, req_addr, req_wdata, resp_ready,
               evict_in_valid, evict_in_addr, l1_evict_ready,
        input  req_ready, resp_valid, resp_type, resp_data,
               evict_in_ready, l1_evict_valid, l1_evict_addr
    );

    modport slave (
        input  req_valid, req_type, req_addr, req_wdata, resp_ready,
               evict_in_valid, evict_in_addr, l1_evict_ready,
        output req_ready, resp_valid, resp_type, resp_data,
               evict_in_ready, l1_evict_valid, l1_evict_addr
    );
endinterface

// File: rtl/l2_line_responder.sv
// l2_line_responder
//   L2-side endpoint of the split-L1 <-> L2 link. Serves L1 line requests
//   (0 data read, 1 write-through, 2 instruction fetch, 3 write-back) from a
//   local line store after a fixed LATENCY, and forwards L2-originated evict
//   commands to the L1 data cache. One transaction in flight at a time.
//
//   Ports:
//     clk, rst  : single clock, synchronous active-high reset
//     bus       : l2_line_responder_if.slave (request, response, evict in,
//                 evict out channels)
//     stat_*    : 32-bit event counters, present only when the macro
//                 L2_RESP_STATS_EN is defined
//
//   Parameters: LINE_BITS (line width), MEM_AW (store index width),
//               LATENCY (1..15, acceptance to resp_valid).
module l2_line_responder #(
    parameter int LINE_BITS = 512,
    parameter int MEM_AW    = 8,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef L2_RESP_STATS_EN
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes,
    output logic [31:0] stat_writebacks,
    output logic [31:0] stat_evicts,
`endif
    l2_line_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        EVICT = 2'd3
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [1:0]           lat_type;
    logic [MEM_AW-1:0]    lat_idx;
    logic [LINE_BITS-1:0] lat_wdata;

    logic                 resp_valid_q;
    logic [1:0]           resp_type_q;
    logic [LINE_BITS-1:0] resp_data_q;
    logic                 l1_evict_valid_q;
    logic [31:0]          l1_evict_addr_q;

    logic [LINE_BITS-1:0] mem [0:(1<<MEM_AW)-1];

    logic                 req_ready_c;
    logic                 evict_ready_c;
    logic                 req_accept;
    logic                 evict_accept;
    logic                 enter_resp;
    logic [1:0]           cur_type;
    logic [MEM_AW-1:0]    cur_idx;
    logic [LINE_BITS-1:0] cur_wdata;
    logic [LINE_BITS-1:0] rd_line;

    // Byte offset and upper tag bits never select anything here.
    logic addr_unused;
    assign addr_unused = ^{bus.req_addr[31:6+MEM_AW], bus.req_addr[5:0],
                           bus.evict_in_addr[5:0]};

    assign req_ready_c   = (state == IDLE) & ~bus.evict_in_valid & ~rst;
    assign evict_ready_c = (state == IDLE) & ~rst;
    assign evict_accept  = bus.evict_in_valid & evict_ready_c;
    assign req_accept    = bus.req_valid & req_ready_c;

    // With LATENCY==1 the store access happens on the acceptance edge, so it
    // must use the live request fields rather than the latched copies.
    always_comb begin
        enter_resp = 1'b0;
        cur_type   = lat_type;
        cur_idx    = lat_idx;
        cur_wdata  = lat_wdata;
        if (state == IDLE && req_accept && LATENCY == 1) begin
            enter_resp = 1'b1;
            cur_type   = bus.req_type;
            cur_idx    = bus.req_addr[6 +: MEM_AW];
            cur_wdata  = bus.req_wdata;
        end else if (state == WAIT && cnt == '0 && !rst) begin
            enter_resp = 1'b1;
        end
    end

    assign rd_line = cur_type[0] ? '0 : mem[cur_idx];

    // Store is never reset; writes commit only on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_type[0]) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            lat_type         <= '0;
            lat_idx          <= '0;
            lat_wdata        <= '0;
            resp_valid_q     <= 1'b0;
            resp_type_q      <= '0;
            resp_data_q      <= '0;
            l1_evict_valid_q <= 1'b0;
            l1_evict_addr_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (evict_accept) begin
                        state            <= EVICT;
                        l1_evict_valid_q <= 1'b1;
                        l1_evict_addr_q  <= {bus.evict_in_addr[31:6], 6'b0};
                    end else if (req_accept) begin
                        lat_type  <= bus.req_type;
                        lat_idx   <= bus.req_addr[6 +: MEM_AW];
                        lat_wdata <= bus.req_wdata;
                        if (LATENCY == 1) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_type_q  <= cur_type;
                            resp_data_q  <= rd_line;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_type_q  <= cur_type;
                        resp_data_q  <= rd_line;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                EVICT: begin
                    if (bus.l1_evict_ready) begin
                        state            <= IDLE;
                        l1_evict_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef L2_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reads      <= '0;
            stat_writes     <= '0;
            stat_writebacks <= '0;
            stat_evicts     <= '0;
        end else begin
            if (req_accept) begin
                if (bus.req_type[0]) begin
                    stat_writes <= stat_writes + 32'd1;
                    if (bus.req_type[1]) begin
                        stat_writebacks <= stat_writebacks + 32'd1;
                    end
                end else begin
                    stat_reads <= stat_reads + 32'd1;
                end
            end
            if (l1_evict_valid_q && bus.l1_evict_ready) begin
                stat_evicts <= stat_evicts + 32'd1;
            end
        end
    end
`endif

    assign bus.req_ready      = req_ready_c;
    assign bus.evict_in_ready = evict_ready_c;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_type      = resp_type_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.l1_evict_valid = l1_evict_valid_q;
    assign bus.l1_evict_addr  = l1_evict_addr_q;

endmodule

// File: tb/tb_l2_line_responder.sv
module tb_l2_line_responder;
    localparam int LINE_BITS = 512;
    localparam int MEM_AW    = 8;
    localparam int LAT       = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_line_responder_if #(.LINE_BITS(LINE_BITS)) b   ();
    l2_line_responder_if #(.LINE_BITS(LINE_BITS)) b1  ();
    l2_line_responder_if #(.LINE_BITS(LINE_BITS)) b15 ();

`ifdef L2_RESP_STATS_EN
    logic [31:0] st_rd, st_wr, st_wb, st_ev;
    logic [31:0] s1 [4];
    logic [31:0] s15 [4];
`endif

    l2_line_responder #(.LINE_BITS(LINE_BITS), .MEM_AW(MEM_AW), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
`ifdef L2_RESP_STATS_EN
        .stat_reads(st_rd), .stat_writes(st_wr), .stat_writebacks(st_wb), .stat_evicts(st_ev),
`endif
        .bus(b)
    );
    l2_line_responder #(.LINE_BITS(LINE_BITS), .MEM_AW(MEM_AW), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
`ifdef L2_RESP_STATS_EN
        .stat_reads(s1[0]), .stat_writes(s1[1]), .stat_writebacks(s1[2]), .stat_evicts(s1[3]),
`endif
        .bus(b1)
    );
    l2_line_responder #(.LINE_BITS(LINE_BITS), .MEM_AW(MEM_AW), .LATENCY(15)) u_dut15 (
        .clk(clk), .rst(rst),
`ifdef L2_RESP_STATS_EN
        .stat_reads(s15[0]), .stat_writes(s15[1]), .stat_writebacks(s15[2]), .stat_evicts(s15[3]),
`endif
        .bus(b15)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: line store as a sparse map of index -> line,
    // plus expected event counts.
    logic [LINE_BITS-1:0] model_mem [int unsigned];
    int unsigned exp_rd = 0, exp_wr = 0, exp_wb = 0, exp_ev = 0;

    function automatic logic [LINE_BITS-1:0] rand_line();
        logic [LINE_BITS-1:0] v;
        for (int k = 0; k < LINE_BITS / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic int unsigned line_idx(input logic [31:0] a);
        return (a >> 6) & ((1 << MEM_AW) - 1);
    endfunction

    // Issue one request on the main DUT (caller is at a negedge) and check
    // latency, hold under backpressure, response contents and completion.
    task automatic do_req(input logic [1:0] t, input logic [31:0] a,
                          input logic [LINE_BITS-1:0] wd, input int stall);
        int n;
        int lat;
        int unsigned idx;
        logic [LINE_BITS-1:0] exp_data;
        logic [LINE_BITS-1:0] held;
        idx = line_idx(a);
        b.req_valid = 1'b1; b.req_type = t; b.req_addr = a; b.req_wdata = wd;
        #1;
        n = 0;
        while (b.req_ready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
        checks++;
        if (b.req_ready !== 1'b1) begin
            errors++; $display("FAIL req_accept_timeout got req_ready=%b want 1", b.req_ready);
            b.req_valid = 1'b0; return;
        end
        if (t[0]) begin
            model_mem[idx] = wd; exp_data = '0; exp_wr++;
            if (t[1]) exp_wb++;
        end else begin
            exp_data = model_mem.exists(idx) ? model_mem[idx] : 'x; exp_rd++;
        end
        @(posedge clk); @(negedge clk);
        b.req_valid = 1'b0;
        lat = 1;
        while (b.resp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        checks++;
        if (lat != LAT) begin
            errors++; $display("FAIL resp_latency got %0d want %0d", lat, LAT);
            if (b.resp_valid !== 1'b1) return;
        end
        held = b.resp_data;
        for (int s = 0; s < stall; s++) begin
            checks++;
            if (b.resp_valid !== 1'b1 || b.resp_data !== held || b.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL resp_hold cycle %0d got valid=%b req_ready=%b data_stable=%b want 1 0 1",
                         s, b.resp_valid, b.req_ready, b.resp_data === held);
            end
            @(negedge clk);
        end
        b.resp_ready = 1'b1;
        #1;
        checks++;
        if (b.resp_type !== t) begin
            errors++; $display("FAIL resp_type got %0d want %0d", b.resp_type, t);
        end
        checks++;
        if (b.resp_data !== exp_data) begin
            errors++; $display("FAIL resp_data got %h want %h", b.resp_data, exp_data);
        end
        @(posedge clk); @(negedge clk);
        b.resp_ready = 1'b0;
        checks++;
        if (b.resp_valid !== 1'b0) begin
            errors++; $display("FAIL resp_done got resp_valid=%b want 0", b.resp_valid);
        end
    endtask

    task automatic do_evict(input logic [31:0] a, input int hold);
        int n;
        logic [31:0] exp_a;
        exp_a = {a[31:6], 6'b0};
        b.evict_in_valid = 1'b1; b.evict_in_addr = a;
        #1;
        n = 0;
        while (b.evict_in_ready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
        checks++;
        if (b.evict_in_ready !== 1'b1) begin
            errors++; $display("FAIL evict_accept_timeout got %b want 1", b.evict_in_ready);
            b.evict_in_valid = 1'b0; return;
        end
        @(posedge clk); @(negedge clk);
        b.evict_in_valid = 1'b0;
        for (int s = 0; s <= hold; s++) begin
            if (s == hold) begin b.l1_evict_ready = 1'b1; #1; end
            checks++;
            if (b.l1_evict_valid !== 1'b1 || b.l1_evict_addr !== exp_a || b.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL evict_hold cycle %0d got valid=%b addr=%h req_ready=%b want 1 %h 0",
                         s, b.l1_evict_valid, b.l1_evict_addr, b.req_ready, exp_a);
            end
            if (s != hold) @(negedge clk);
        end
        @(posedge clk); @(negedge clk);
        b.l1_evict_ready = 1'b0;
        exp_ev++;
        checks++;
        if (b.l1_evict_valid !== 1'b0) begin
            errors++; $display("FAIL evict_done got l1_evict_valid=%b want 0", b.l1_evict_valid);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef L2_RESP_STATS_EN
        checks++;
        if (st_rd !== exp_rd || st_wr !== exp_wr || st_wb !== exp_wb || st_ev !== exp_ev) begin
            errors++;
            $display("FAIL stats_%s got rd=%0d wr=%0d wb=%0d ev=%0d want %0d %0d %0d %0d",
                     tag, st_rd, st_wr, st_wb, st_ev, exp_rd, exp_wr, exp_wb, exp_ev);
        end
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (b.resp_valid !== 1'b0 || b.resp_type !== 2'd0 || b.resp_data !== '0 ||
            b.l1_evict_valid !== 1'b0 || b.l1_evict_addr !== 32'd0 ||
            b.req_ready !== 1'b0 || b.evict_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s got rv=%b rt=%0d rd_zero=%b ev=%b ea=%h rr=%b er=%b want all 0",
                     tag, b.resp_valid, b.resp_type, b.resp_data === '0, b.l1_evict_valid,
                     b.l1_evict_addr, b.req_ready, b.evict_in_ready);
        end
        exp_rd = 0; exp_wr = 0; exp_wb = 0; exp_ev = 0;
        check_stats(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        b.req_valid = 1'b1; b.evict_in_valid = 1'b1;
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        b.req_valid = 1'b0; b.evict_in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (b.req_ready !== 1'b1 || b.evict_in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset got %b %b want 1 1", b.req_ready, b.evict_in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [LINE_BITS-1:0] pat;
        pat = {(LINE_BITS/8){8'hA5}};
        do_req(2'd1, 32'h0000_0040, pat, 0);
        do_req(2'd0, 32'h0000_0040, '0, 0);
    endtask

    task automatic test_alias();
        do_req(2'd3, 32'h1234_5680, rand_line(), 0);
        do_req(2'd2, 32'h0000_5680, '0, 0);
        check_stats("alias");
    endtask

    task automatic test_evict_priority();
        b.req_valid = 1'b1; b.req_type = 2'd0; b.req_addr = 32'h0000_0040; b.req_wdata = '0;
        b.evict_in_valid = 1'b1; b.evict_in_addr = 32'h0ABC_DE7F;
        #1;
        checks++;
        if (b.req_ready !== 1'b0 || b.evict_in_ready !== 1'b1) begin
            errors++; $display("FAIL evict_priority got req_ready=%b evict_in_ready=%b want 0 1",
                               b.req_ready, b.evict_in_ready);
        end
        do_evict(32'h0ABC_DE7F, 3);
        checks++;
        if (b.req_ready !== 1'b1) begin
            errors++; $display("FAIL req_after_evict got req_ready=%b want 1", b.req_ready);
        end
        do_req(2'd0, 32'h0000_0040, '0, 0);
    endtask

    task automatic test_backpressure();
        do_req(2'd0, 32'h0000_5680, '0, 5);
    endtask

    task automatic test_random();
        logic [1:0]  t;
        logic [31:0] a;
        int unsigned idx;
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, 7);
            a = ($urandom() & ~32'h0000_3FC0) | (idx << 6);
            if ($urandom_range(0, 4) == 0) begin
                do_evict(a, $urandom_range(0, 3));
            end else begin
                t = 2'($urandom_range(0, 3));
                if (!t[0] && !model_mem.exists(idx)) t = 2'd1;
                do_req(t, a, rand_line(), $urandom_range(0, 3));
            end
        end
        check_stats("random");
    endtask

    task automatic test_reset_mid();
        logic [LINE_BITS-1:0] newer;
        do_req(2'd1, 32'h0000_0100, rand_line(), 0);
        do_evict(32'hFFFF_FFFF, 0);
        newer = rand_line();
        b.req_valid = 1'b1; b.req_type = 2'd1; b.req_addr = 32'h0000_0100; b.req_wdata = newer;
        #1;
        checks++;
        if (b.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_accept got req_ready=%b want 1", b.req_ready);
        end
        @(posedge clk); @(negedge clk);
        b.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check_reset_outputs("reset_mid");
        rst = 1'b0;
        @(negedge clk);
        do_req(2'd0, 32'h0000_0100, '0, 0);
    endtask

    task automatic corner_txn(input logic [1:0] t, input logic [31:0] a,
                              input logic [LINE_BITS-1:0] wd, input logic [LINE_BITS-1:0] exp_d);
        int lat1, lat15, cnt1, cnt15;
        logic [LINE_BITS-1:0] d1, d15;
        logic [1:0] t1, t15;
        b1.req_valid = 1'b1;  b1.req_type = t;  b1.req_addr = a;  b1.req_wdata = wd;  b1.resp_ready = 1'b1;
        b15.req_valid = 1'b1; b15.req_type = t; b15.req_addr = a; b15.req_wdata = wd; b15.resp_ready = 1'b1;
        #1;
        checks++;
        if (b1.req_ready !== 1'b1 || b15.req_ready !== 1'b1) begin
            errors++; $display("FAIL corner_accept got %b %b want 1 1", b1.req_ready, b15.req_ready);
        end
        @(posedge clk); @(negedge clk);
        b1.req_valid = 1'b0; b15.req_valid = 1'b0;
        lat1 = 0; lat15 = 0; cnt1 = 0; cnt15 = 0; d1 = '0; d15 = '0; t1 = '0; t15 = '0;
        for (int c = 1; c <= 20; c++) begin
            if (b1.resp_valid === 1'b1) begin
                if (cnt1 == 0) begin lat1 = c; d1 = b1.resp_data; t1 = b1.resp_type; end
                cnt1++;
            end
            if (b15.resp_valid === 1'b1) begin
                if (cnt15 == 0) begin lat15 = c; d15 = b15.resp_data; t15 = b15.resp_type; end
                cnt15++;
            end
            @(negedge clk);
        end
        checks++;
        if (lat1 != 1 || cnt1 != 1) begin
            errors++; $display("FAIL latency_1 got lat=%0d cycles=%0d want 1 1", lat1, cnt1);
        end
        checks++;
        if (lat15 != 15 || cnt15 != 1) begin
            errors++; $display("FAIL latency_15 got lat=%0d cycles=%0d want 15 1", lat15, cnt15);
        end
        checks++;
        if (d1 !== exp_d || d15 !== exp_d || t1 !== t || t15 !== t) begin
            errors++; $display("FAIL corner_resp got t=%0d/%0d d1=%h want t=%0d d=%h", t1, t15, d1, t, exp_d);
        end
        b1.resp_ready = 1'b0; b15.resp_ready = 1'b0;
    endtask

    task automatic test_latency_corners();
        logic [LINE_BITS-1:0] v;
        v = rand_line();
        corner_txn(2'd1, 32'h0000_0080, v, '0);
        corner_txn(2'd0, 32'h0000_0080, '0, v);
    endtask

    initial begin
        rst = 1'b1;
        b.req_valid = 1'b0; b.req_type = '0; b.req_addr = '0; b.req_wdata = '0;
        b.resp_ready = 1'b0; b.evict_in_valid = 1'b0; b.evict_in_addr = '0; b.l1_evict_ready = 1'b0;
        b1.req_valid = 1'b0; b1.req_type = '0; b1.req_addr = '0; b1.req_wdata = '0;
        b1.resp_ready = 1'b0; b1.evict_in_valid = 1'b0; b1.evict_in_addr = '0; b1.l1_evict_ready = 1'b0;
        b15.req_valid = 1'b0; b15.req_type = '0; b15.req_addr = '0; b15.req_wdata = '0;
        b15.resp_ready = 1'b0; b15.evict_in_valid = 1'b0; b15.evict_in_addr = '0; b15.l1_evict_ready = 1'b0;
        test_reset();
        test_write_read();
        test_alias();
        test_evict_priority();
        test_backpressure();
        test_random();
        test_reset_mid();
        check_stats("final");
        test_latency_corners();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/l2_line_responder.md
Name: l2_line_responder

Overview:
- L2-side endpoint of the split-L1 ↔ L2 interface; the other end of the L1 cache's L2 traffic.
- Accepts L1 line requests: data read, write-through, instruction fetch and dirty write-back. Serves them from a local line store after a fixed latency.
- Forwards L2-originated evict commands to the L1 data cache.
- One transaction is in flight at a time, so requests are strictly ordered.

Parameters:
- LINE_BITS, 512, line width in bits (64-byte line, 6-bit byte offset).
- MEM_AW, 8, line-store index width; store depth is 2**MEM_AW lines.
- LATENCY, 4, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  L1 request present.
- req_ready  out  1  responder can accept a request.
- req_type  in  2  0=data read, 1=write-through, 2=instruction fetch, 3=write-back.
- req_addr  in  32  byte address; bits [5:0] are ignored.
- req_wdata  in  LINE_BITS  line data for types 1 and 3.
- resp_valid  out  1  response present.
- resp_ready  in  1  L1 accepts the response.
- resp_type  out  2  echo of req_type.
- resp_data  out  LINE_BITS  line data for types 0/2; zero for types 1/3.
- evict_in_valid  in  1  L2 control requests an L1 eviction.
- evict_in_ready  out  1  eviction command accepted.
- evict_in_addr  in  32  line address to evict.
- l1_evict_valid  out  1  evict command to L1.
- l1_evict_ready  in  1  L1 accepted the evict.
- l1_evict_addr  out  32  evicted address with bits [5:0] forced to 0.

Behaviour:
- FSM states: IDLE, WAIT, RESP, EVICT.
- Reset values: state=IDLE, req_ready=0 during rst, resp_valid=0, resp_type=0, resp_data=0, evict_in_ready=0, l1_evict_valid=0, l1_evict_addr=0, latency counter=0. Line-store contents are not cleared; reads of unwritten lines return X.
- Ready signals:
  - req_ready = (state==IDLE) & ~evict_in_valid & ~rst.
  - evict_in_ready = (state==IDLE) & ~rst.
  - Both are combinational.
- Evict priority: when both evict_in_valid and req_valid are high in IDLE, the evict is accepted and the request waits. req_valid must be held by the sender until it is accepted.
- Request acceptance: req_valid & req_ready at edge T latches type, index = req_addr[6 +: MEM_AW] and wdata. Upper address bits are ignored, so addresses alias modulo the store depth.
- Latency path:
  - LATENCY=1: go straight to RESP.
  - LATENCY>1: go to WAIT, load the counter with LATENCY-2, decrement each cycle, and go to RESP when the counter is 0.
  - In both cases resp_valid rises exactly LATENCY cycles after T.
- Entering RESP:
  - Types 1 and 3 write the latched wdata into store[index] on that edge.
  - Types 0 and 2 register store[index] into resp_data.
  - A read issued after a write to the same index returns the new data.
- RESP: resp_valid and resp_type/resp_data are held stable until resp_valid & resp_ready. Then go to IDLE with resp_valid=0 on the next cycle. No back-to-back acceptance in the handshake cycle.
- EVICT:
  - Entered on evict_in_valid & evict_in_ready; l1_evict_addr = {evict_in_addr[31:6], 6'b0}.
  - l1_evict_valid is held with a stable address until l1_evict_ready, then go to IDLE.
  - The line store is not modified by an evict.
- rst asserted in any state aborts the transaction: the pending response or evict is dropped, and a pending write that has not reached RESP is not committed.

Optional Feature:
- Macro L2_RESP_STATS_EN.
- When defined, adds these output ports, each 32 bits wide, reset to 0 and wrapping mod 2**32:
  - stat_reads: counts accepted type 0 and type 2 requests.
  - stat_writes: counts accepted type 1 and type 3 requests.
  - stat_writebacks: counts accepted type 3 requests only.
  - stat_evicts: counts completed l1_evict handshakes.
  - Counters increment on the acceptance edge.
- When not defined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Write then read: type1 addr 0x0000_0040 wdata=0xA5 repeated, resp_ready=1 → resp_valid at T+4 with resp_type=1 and resp_data=0. Then type0 same addr → resp_data=0xA5 pattern exactly 4 cycles after acceptance.
- Aliasing: type3 to 0x1234_5680, then type2 to 0x0000_5680 → same line returned (index 0x5A). stat_writebacks=1 with L2_RESP_STATS_EN.
- Simultaneous arrival: evict_in_valid=1 addr 0x0ABC_DE7F and req_valid=1 in the same IDLE cycle → evict accepted first, l1_evict_addr=0x0ABC_DE40, req_ready=0. Hold l1_evict_ready=0 for 3 cycles (address stable); the request is accepted the cycle after the evict handshake.
- Backpressure: read completes with resp_ready=0 for 5 cycles → resp_valid and resp_data held stable and req_ready=0 throughout; one response only after resp_ready=1.
- Latency corner: LATENCY=1 → resp_valid asserted the cycle after acceptance. LATENCY=15 → asserted exactly 15 cycles after acceptance.
- Reset mid-operation: rst pulsed during WAIT of a type1 write → all outputs at reset values next cycle. A subsequent read of that index returns prior contents, proving the write was not committed.
